// File: rtl/gate_frame_accum_if.sv
// Beat-in / frame-result-out handshake bundle for gate_frame_accum.
// out_parity exists only when GATE_ACC_PARITY_EN is defined.
interface gate_frame_accum_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_ovf;
`ifdef GATE_ACC_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
`ifdef GATE_ACC_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
`ifdef GATE_ACC_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/gate_frame_accum.sv
// Folds a frame of (a op b) beats into one registered result on a valid/ready output.
// Optional GATE_ACC_PARITY_EN adds a registered out_parity = ^out_data.
module gate_frame_accum #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic               clk,
  input logic               rst_n,
  gate_frame_accum_if.slave bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_count;
  logic             r_out_ovf;

  logic             w_ready;
  logic             w_fire;
  logic             w_first;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_beat;
  logic [WIDTH-1:0] w_acc_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_ovf_next;

  assign w_ready = (r_state != S_HOLD) || bus.out_ready;
  assign w_fire  = bus.in_valid && w_ready;
  // A beat taken in IDLE or in HOLD (same-cycle release) opens a new frame.
  assign w_first = (r_state != S_ACCUM);
  assign w_op    = w_first ? bus.in_op : r_op;

  always_comb begin
    w_beat = '0;
    unique case (w_op)
      2'b00:   w_beat = bus.in_a & bus.in_b;
      2'b01:   w_beat = bus.in_a | bus.in_b;
      2'b10:   w_beat = bus.in_a ^ bus.in_b;
      default: w_beat = (bus.in_a & bus.in_b) & (bus.in_a | bus.in_b);
    endcase
  end

  always_comb begin
    w_acc_next = w_beat;
    w_cnt_next = CW'(1);
    w_ovf_next = 1'b0;
    if (!w_first) begin
      unique case (w_op)
        2'b01:   w_acc_next = r_acc | w_beat;
        2'b10:   w_acc_next = r_acc ^ w_beat;
        default: w_acc_next = r_acc & w_beat;
      endcase
      w_cnt_next = (r_cnt == MAXC) ? MAXC : r_cnt + CW'(1);
      w_ovf_next = r_ovf || (r_cnt == MAXC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_fire) begin
      r_op  <= w_op;
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
      if (bus.in_last) begin
        r_out_data  <= w_acc_next;
        r_out_count <= w_cnt_next;
        r_out_ovf   <= w_ovf_next;
        r_state     <= S_HOLD;
      end else begin
        r_state <= S_ACCUM;
      end
    end else if (r_state == S_HOLD && bus.out_ready) begin
      r_state <= S_IDLE;
    end
  end

`ifdef GATE_ACC_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_parity <= 1'b0;
    else if (w_fire && bus.in_last)
      r_parity <= ^w_acc_next;
  end
  assign bus.out_parity = r_parity;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_gate_frame_accum.sv
// Directed bench for gate_frame_accum with hand-computed frame results.
// Parity checks are included when GATE_ACC_PARITY_EN is defined.
module tb_gate_frame_accum;
  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gate_frame_accum_if #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) bus ();

  gate_frame_accum #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Offer one beat just after a rising edge; it is taken on the next edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [4:0] c, input logic o);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
    chk({tag, "_ovf"},   32'(bus.out_ovf),   32'(o));
  endtask

  initial begin
    logic [7:0] one_hot;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 2'b00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk_out("rst", 1'b0, 8'h00, 5'd0, 1'b0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat AND frame
    send(8'hF0, 8'h3C, 2'b00, 1'b1);
    chk_out("and1", 1'b1, 8'h30, 5'd1, 1'b0);

    // XOR frame back-to-back; op change on beat 2 must be ignored
    send(8'h01, 8'h00, 2'b10, 1'b0);
    chk("xor_b1_valid", 32'(bus.out_valid), 32'd0);
    chk("xor_b1_data_held", 32'(bus.out_data), 32'h30);
    send(8'h02, 8'h00, 2'b00, 1'b0);
    send(8'h01, 8'h00, 2'b00, 1'b1);
    chk_out("xor3", 1'b1, 8'h02, 5'd3, 1'b0);
    @(posedge clk);
    #1;
    chk("xor3_released", 32'(bus.out_valid), 32'd0);
    chk("xor3_data_held", 32'(bus.out_data), 32'h02);

    // OR frame of 18 beats: count saturates at 16, ovf set
    for (int i = 0; i < MAX_BEATS + 2; i++) begin
      one_hot = 8'h01 << (i % 8);
      send(one_hot, 8'h00, 2'b01, (i == MAX_BEATS + 1));
      if (i == MAX_BEATS - 1) chk("or_mid_valid", 32'(bus.out_valid), 32'd0);
    end
    chk_out("or18", 1'b1, 8'hFF, 5'd16, 1'b1);

    send(8'h01, 8'h02, 2'b01, 1'b0);
    send(8'h04, 8'h00, 2'b01, 1'b1);
    bus.out_ready = 1'b0;
    #1;
    chk_out("or2", 1'b1, 8'h07, 5'd2, 1'b0);
    chk("hold_in_ready", 32'(bus.in_ready), 32'd0);

    // Held result with a beat offered must not be disturbed
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    bus.in_op    = 2'b00;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_out("hold", 1'b1, 8'h07, 5'd2, 1'b0);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
    end

    // Release and accept a single-beat BOTH frame in the same cycle
    bus.in_a      = 8'hAA;
    bus.in_b      = 8'hAA;
    bus.in_op     = 2'b11;
    bus.out_ready = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_out("both1", 1'b1, 8'hAA, 5'd1, 1'b0);
    @(posedge clk);
    #1;

    // Reset in the middle of a 4-beat frame
    send(8'h0F, 8'hFF, 2'b00, 1'b0);
    send(8'h0F, 8'hFF, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 8'h00, 5'd0, 1'b0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hF0, 8'hFF, 2'b00, 1'b1);
    chk_out("post_rst", 1'b1, 8'hF0, 5'd1, 1'b0);

    // Multi-beat BOTH folds with AND
    send(8'hAA, 8'hAA, 2'b11, 1'b0);
    send(8'hF0, 8'hFF, 2'b01, 1'b1);
    chk_out("both2", 1'b1, 8'hA0, 5'd2, 1'b0);

    send(8'h3C, 8'h0F, 2'b10, 1'b1);
    chk_out("xor1", 1'b1, 8'h33, 5'd1, 1'b0);

`ifdef GATE_ACC_PARITY_EN
    send(8'h07, 8'hFF, 2'b00, 1'b1);
    chk_out("par", 1'b1, 8'h07, 5'd1, 1'b0);
    chk("par_bit", 32'(bus.out_parity), 32'd1);
    send(8'h03, 8'hFF, 2'b00, 1'b1);
    chk("par_bit_even", 32'(bus.out_parity), 32'd0);
`endif

    @(posedge clk);
    #1;
    chk("final_idle", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
